// File: rtl/n_clic_ext_irq_pkg.sv
// Shared types and constants for the n_clic external interrupt front end:
// CSR op encoding, trigger modes, CSR addresses and the CSR read-modify-write helper.
package n_clic_ext_irq_pkg;

  localparam int XLEN      = 32;
  localparam int VecSize   = 16;
  localparam int VecW      = $clog2(VecSize);
  localparam int CsrAddrW  = 12;
  localparam int NumExtIrq = 4;

  localparam logic [CsrAddrW-1:0] ExtIrqCfgAddr = 12'h7C0;
  localparam logic [CsrAddrW-1:0] ExtIrqOvfAddr = 12'h7C1;

  typedef enum logic [1:0] {
    TRIG_OFF   = 2'b00,
    TRIG_RISE  = 2'b01,
    TRIG_FALL  = 2'b10,
    TRIG_LEVEL = 2'b11
  } trig_mode_t;

  // Bit 2 selects the immediate operand; bits [1:0] select write/set/clear.
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } ext_irq_state_t;

  function automatic logic [XLEN-1:0] csr_apply(input logic [2:0] op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] operand);
    logic [XLEN-1:0] res;
    res = old_val;
    case (op[1:0])
      2'b01:   res = operand;
      2'b10:   res = old_val | operand;
      2'b11:   res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/n_clic_irq_sync.sv
// One external pin: synchronizer chain, previous-value flop and trigger-mode event decode.
// The event output is combinational from the synchronized value and its one-cycle-old copy.
module n_clic_irq_sync
  import n_clic_ext_irq_pkg::*;
#(
  parameter int SyncStages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin,
  input  logic [1:0] mode,
  output logic       evt
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  s;

  assign s = sync_q[SyncStages-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin};
      prev_q <= s;
    end
  end

  always_comb begin
    evt = 1'b0;
    case (trig_mode_t'(mode))
      TRIG_RISE:  evt = s & ~prev_q;
      TRIG_FALL:  evt = ~s & prev_q;
      TRIG_LEVEL: evt = s;
      default:    evt = 1'b0;
    endcase
  end

endmodule

// File: rtl/n_clic_ext_irq.sv
// External interrupt pend-request source for n_clic: per-pin event latches with sticky
// overflow, trigger-mode and overflow CSRs, and a round-robin valid/ack pend offer.
module n_clic_ext_irq
  import n_clic_ext_irq_pkg::*;
#(
  parameter int                  NumSrc     = 4,
  parameter int                  SyncStages = 2,
  parameter int                  BaseIndex  = 1,
  parameter logic [CsrAddrW-1:0] CfgAddr    = ExtIrqCfgAddr,
  parameter logic [CsrAddrW-1:0] OvfAddr    = ExtIrqOvfAddr
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NumSrc-1:0]   ext_irq_in,
  input  logic                csr_enable,
  input  logic [CsrAddrW-1:0] csr_addr,
  input  logic [2:0]          csr_op,
  input  logic [4:0]          rs1_zimm,
  input  logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     csr_out,
  output logic                pend_valid,
  output logic [VecW-1:0]     pend_index,
  input  logic                pend_ack
);

  localparam int GrantW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  ext_irq_state_t          state_q, state_d;
  logic [2*NumSrc-1:0]     cfg_q, cfg_d;
  logic [NumSrc-1:0]       ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [NumSrc-1:0]       latch_q, latch_d;
  logic [NumSrc-1:0]       evt;
  logic [GrantW-1:0]       rr_q, rr_d, grant_q, grant_d;
  logic                    pend_valid_d;
  logic [VecW-1:0]         pend_index_d;
  logic                    ack_fire;

  logic [XLEN-1:0]         operand, cfg_word, ovf_word, cfg_new;
  logic                    cfg_sel, ovf_sel;

  for (genvar g = 0; g < NumSrc; g++) begin : g_src
    n_clic_irq_sync #(.SyncStages(SyncStages)) u_sync (
      .clk   (clk),
      .reset (reset),
      .pin   (ext_irq_in[g]),
      .mode  (cfg_q[2*g +: 2]),
      .evt   (evt[g])
    );
  end

  // CSR access
  assign operand  = csr_op[2] ? {{(XLEN-5){1'b0}}, rs1_zimm} : rs1_data;
  assign cfg_word = XLEN'(cfg_q);
  assign ovf_word = XLEN'(ovf_q);
  assign cfg_sel  = csr_enable && (csr_addr == CfgAddr);
  assign ovf_sel  = csr_enable && (csr_addr == OvfAddr);
  assign cfg_new  = csr_apply(csr_op, cfg_word, operand);
  assign cfg_d    = cfg_sel ? cfg_new[2*NumSrc-1:0] : cfg_q;
  assign ovf_clr  = (ovf_sel && (csr_op[1:0] == 2'b11)) ? operand[NumSrc-1:0] : '0;
  // A new overflow wins over a same-cycle software clear.
  assign ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;

  always_comb begin
    csr_out = '0;
    if (csr_addr == CfgAddr)      csr_out = cfg_word;
    else if (csr_addr == OvfAddr) csr_out = ovf_word;
  end

  // Offer FSM with round-robin grant starting at rr_q
  always_comb begin
    int idx;
    int found;
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    pend_valid_d = pend_valid;
    pend_index_d = pend_index;
    ack_fire     = 1'b0;
    found        = 0;
    idx          = 0;
    case (state_q)
      ST_IDLE: begin
        if (|latch_q) begin
          for (int off = NumSrc - 1; off >= 0; off--) begin
            idx = (int'(rr_q) + off) % NumSrc;
            if (latch_q[idx]) found = idx;
          end
          grant_d      = GrantW'(found);
          pend_index_d = VecW'(BaseIndex + found);
          pend_valid_d = 1'b1;
          state_d      = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (pend_ack) begin
          ack_fire     = 1'b1;
          pend_valid_d = 1'b0;
          rr_d         = (int'(grant_q) == NumSrc - 1) ? '0 : GrantW'(int'(grant_q) + 1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches: a fresh event beats the ack clear; only edge modes can overflow.
  always_comb begin
    logic held;
    logic clr;
    logic is_edge;
    latch_d = latch_q;
    ovf_set = '0;
    for (int i = 0; i < NumSrc; i++) begin
      held    = (state_q == ST_OFFER) && (int'(grant_q) == i);
      clr     = ack_fire && (int'(grant_q) == i);
      is_edge = (trig_mode_t'(cfg_q[2*i +: 2]) == TRIG_RISE) ||
                (trig_mode_t'(cfg_q[2*i +: 2]) == TRIG_FALL);
      if ((trig_mode_t'(cfg_q[2*i +: 2]) == TRIG_OFF) && !held && !clr) begin
        latch_d[i] = 1'b0;
      end else if (evt[i]) begin
        latch_d[i] = 1'b1;
        if (is_edge && latch_q[i] && !clr) ovf_set[i] = 1'b1;
      end else if (clr) begin
        latch_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      ovf_q      <= '0;
      latch_q    <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      pend_valid <= 1'b0;
      pend_index <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      ovf_q      <= ovf_d;
      latch_q    <= latch_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      pend_valid <= pend_valid_d;
      pend_index <= pend_index_d;
    end
  end

endmodule

// File: doc/n_clic_ext_irq.md
Name: n_clic_ext_irq

Overview:
Upstream pend-request source for n_clic. It samples NumSrc asynchronous external interrupt pins and detects level or edge events per source according to a CSR-programmed trigger mode. Captured events are offered one at a time over a valid/ack handshake that pends vector entry BaseIndex+i in n_clic. Lost events (an event arriving while the same source is still latched) are recorded in a sticky overflow CSR.

Parameters:
NumSrc, 4, number of external interrupt pins; 1..16 (2 config bits each must fit in one word).
SyncStages, 2, synchronizer flops per pin; minimum 2.
BaseIndex, 1, vector index of source 0; index 0 is reserved for the timer; BaseIndex+NumSrc <= VecSize.
CfgAddr, ExtIrqCfgAddr, CSR address of the trigger-mode register.
OvfAddr, ExtIrqOvfAddr, CSR address of the overflow register.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ext_irq_in  in  NumSrc  asynchronous interrupt pins
csr_enable  in  1  CSR instruction strobe
csr_addr  in  CsrAddrT  CSR address
csr_op  in  csr_op_t  CSR operation
rs1_zimm  in  r  5-bit immediate
rs1_data  in  word  register operand
csr_out  out  word  read data; 0 when the address matches neither CSR
pend_valid  out  1  pend request offered
pend_index  out  VecT  vector entry to pend
pend_ack  in  1  n_clic accepted the pend this cycle

Behaviour:
- Reset (synchronous, active-high): sync flops, prev flops, request latches, overflow, cfg, rr pointer cleared to 0; state IDLE; pend_valid=0, pend_index=0. Reset during OFFER drops the request with no ack required.
- Cfg CSR: 2 bits per source i at [2i+1:2i]. 00 disabled, 01 rising, 10 falling, 11 level-high. Full csr_op semantics (RW/RS/RC and immediate forms). Bits above 2*NumSrc read as 0.
- Ovf CSR: bit i is sticky. Reads return the value. CSRRC/CSRRCI clear the selected bits; all other ops leave it unchanged. Set has priority over clear in the same cycle.
- Sync: the pin passes through SyncStages flops. prev = last synced value, updated every cycle regardless of mode. Event: rising = s & ~prev; falling = ~s & prev; level = s.
- Latency: a pin transition before clock edge k (SyncStages=2) sets its request latch at edge k+2. pend_valid rises at edge k+3 at the earliest.
- Overflow: an edge event while latch[i] is already set (and not being cleared that cycle) sets ovf[i]. Level mode never sets overflow.
- Disabled source: latch[i] clears on the next edge unless i is currently granted; a granted request always completes.
- FSM IDLE:
  - If any latch is set, grant the first set index at or after rr_ptr, wrapping modulo NumSrc.
  - Register pend_index = BaseIndex + grant and pend_valid = 1, then go to OFFER.
- FSM OFFER:
  - pend_valid and pend_index are held stable until pend_ack.
  - On pend_ack: clear latch[grant]; a same-cycle new event on that source wins and the latch stays set.
  - Set rr_ptr = (grant+1) mod NumSrc, pend_valid = 0, go to IDLE.
  - Throughput: at most one pend every 2 cycles.
- pend_ack outside OFFER is ignored.
- Level source held high: it re-latches immediately after ack, so it re-pends every 2 cycles while high. This is intended, since n_clic pends are idempotent.

Decomposition:
- config_pkg gains: NumExtIrq, ExtIrqCfgAddr, ExtIrqOvfAddr, and trig_mode_t enum {TRIG_OFF, TRIG_RISE, TRIG_FALL, TRIG_LEVEL} (2 bits).
- Sub-module n_clic_irq_sync: one pin; synchronizer, prev flop and event output for a given trig_mode_t. Instantiated NumSrc times with a generate loop.

Test Plan:
- Cfg=0x01 (src0 rising); pulse ext_irq_in[0] high before edge 10 -> pend_valid=1 after edge 13 with pend_index=1; pend_ack at cycle 15 -> pend_valid=0 after edge 15.
- Cfg=0xFF (all level); pins 0..3 held high; ack every cycle -> pend_index sequence 1,2,3,4,1 (round robin); no ovf bits set.
- Cfg=0x02 (src0 falling); two falling edges before ack, withheld for 10 cycles -> exactly one pend, Ovf CSR reads 0x1; CSRRCI Ovf,1 -> reads 0x0.
- Rising edge on src2 landing in the same cycle as the ack of src2 -> latch remains set; a second pend with pend_index=3 follows within 2 cycles; no overflow.
- Reset asserted while in OFFER with pend_valid=1 -> after the edge pend_valid=0, Cfg=0, Ovf=0, pins ignored until reconfigured.
- CSR read at an unmatched address -> csr_out=0; write Cfg=0xFFFFFFFF with NumSrc=4 -> readback 0x000000FF.
